elevator_call_scheduler: RTL and testbench

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

---
 rtl/elevator_call_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Purpose:
//   Single-car elevator call scheduler. Floor call buttons are latched into a
//   pending mask on every clock. A four-state controller (IDLE, MOVE_UP,
//   MOVE_DOWN, DOOR) advances only on clock edges qualified by tick.
//   - It keeps travelling in its preferred direction while calls remain ahead.
//   - It stops at each pending floor and holds the door open for DOOR_TICKS
//     ticks.
//   - A call at the current floor while the door is open restarts the dwell.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   tick        in   one-clk step enable; the controller advances only on it
//   call_req    in   [NUM_FLOORS] call buttons, bit i = floor i
//   cur_floor   out  [FLOOR_W] current car floor
//   next_floor  out  [FLOOR_W] floor the car is heading to this step
//   pending     out  [NUM_FLOORS] latched outstanding calls
//   dir_up      out  travel preference, 1 = up
//   moving      out  high in MOVE_UP / MOVE_DOWN
//   door_open   out  high in DOOR
//   busy        out  high when not IDLE or any call pending
//
// All outputs are decoded from registered state only, so there is no
// combinational path from an input to an output.
// -----------------------------------------------------------------------------
module elevator_call_scheduler #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    next_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  busy
);

  // Dwell counter only has to hold DOOR_TICKS-1 down to 0.
  localparam int CNT_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(DOOR_TICKS - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_FLOOR  = {FLOOR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } state_e;

  // One-hot decode of a floor index onto the call mask. Indices beyond
  // NUM_FLOORS-1 decode to all zeros, so an out-of-range floor never
  // addresses a nonexistent pending bit.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] oh;
    oh = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      oh[i] = (FLOOR_W'(i) == f);
    end
    return oh;
  endfunction

  state_e                state_q,     state_d;
  logic [FLOOR_W-1:0]    cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0] pending_q,   pending_d;
  logic                  dir_up_q,    dir_up_d;
  logic [CNT_W-1:0]      door_cnt_q,  door_cnt_d;

  logic [FLOOR_W-1:0]    up_floor;
  logic [FLOOR_W-1:0]    dn_floor;
  logic [NUM_FLOORS-1:0] cur_oh;
  logic [NUM_FLOORS-1:0] up_oh;
  logic [NUM_FLOORS-1:0] dn_oh;
  logic                  call_above;
  logic                  call_below;
  logic                  hit_here;
  logic                  hit_up;
  logic                  hit_dn;
  logic                  door_call;
  logic [NUM_FLOORS-1:0] door_mask;
  logic [NUM_FLOORS-1:0] serve_mask;

  assign up_floor  = cur_floor_q + FLOOR_W'(1);
  assign dn_floor  = cur_floor_q - FLOOR_W'(1);
  assign cur_oh    = floor_onehot(cur_floor_q);
  assign up_oh     = floor_onehot(up_floor);
  assign dn_oh     = floor_onehot(dn_floor);
  assign hit_here  = |(pending_q & cur_oh);
  assign hit_up    = |(pending_q & up_oh);
  assign hit_dn    = |(pending_q & dn_oh);

  // While the door is open, a press at the current floor restarts the dwell
  // instead of being latched as a new call.
  assign door_call = (state_q == ST_DOOR) && (|(call_req & cur_oh));
  assign door_mask = (state_q == ST_DOOR) ? cur_oh : {NUM_FLOORS{1'b0}};

  // Scan the pending mask for calls strictly above / below the car.
  always_comb begin
    call_above = 1'b0;
    call_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      call_above = call_above | (pending_q[i] & (FLOOR_W'(i) > cur_floor_q));
      call_below = call_below | (pending_q[i] & (FLOOR_W'(i) < cur_floor_q));
    end
  end

  // Next-state logic for the controller, floor, direction and dwell counter.
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    door_cnt_d  = door_cnt_q;
    serve_mask  = {NUM_FLOORS{1'b0}};
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (hit_here) begin
            state_d    = ST_DOOR;
            serve_mask = cur_oh;
            door_cnt_d = CNT_RELOAD;
          end else if (call_above && call_below) begin
            // Calls on both sides: keep the current preference.
            state_d = dir_up_q ? ST_MOVE_UP : ST_MOVE_DOWN;
          end else if (call_above) begin
            state_d  = ST_MOVE_UP;
            dir_up_d = 1'b1;
          end else if (call_below) begin
            state_d  = ST_MOVE_DOWN;
            dir_up_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MOVE_UP: begin
          // Without a call above there is nothing to step towards; this also
          // keeps the car from ever stepping past the top floor.
          if (!call_above) begin
            state_d = ST_IDLE;
          end else begin
            cur_floor_d = up_floor;
            if (hit_up) begin
              state_d    = ST_DOOR;
              serve_mask = up_oh;
              door_cnt_d = CNT_RELOAD;
            end else begin
              state_d = ST_MOVE_UP;
            end
          end
        end
        ST_MOVE_DOWN: begin
          if (!call_below) begin
            state_d = ST_IDLE;
          end else begin
            cur_floor_d = dn_floor;
            if (hit_dn) begin
              state_d    = ST_DOOR;
              serve_mask = dn_oh;
              door_cnt_d = CNT_RELOAD;
            end else begin
              state_d = ST_MOVE_DOWN;
            end
          end
        end
        ST_DOOR: begin
          // A restart press wins over the dwell expiring on the same edge.
          if (door_call) begin
            door_cnt_d = CNT_RELOAD;
          end else if (door_cnt_q != {CNT_W{1'b0}}) begin
            door_cnt_d = door_cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      // The dwell restart is honoured on every clock, not only on ticks.
      if (door_call) begin
        door_cnt_d = CNT_RELOAD;
      end else begin
        door_cnt_d = door_cnt_q;
      end
    end
  end

  // Latch new calls; clearing the floor being served wins over a same-edge set.
  always_comb begin
    pending_d = (pending_q | (call_req & ~door_mask)) & ~serve_mask;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_floor_q <= BOT_FLOOR;
      pending_q   <= {NUM_FLOORS{1'b0}};
      dir_up_q    <= 1'b1;
      door_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      door_cnt_q  <= door_cnt_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    next_floor = cur_floor_q;
    moving     = 1'b0;
    door_open  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        next_floor = cur_floor_q;
      end
      ST_MOVE_UP: begin
        moving     = 1'b1;
        next_floor = (cur_floor_q == TOP_FLOOR) ? cur_floor_q : up_floor;
      end
      ST_MOVE_DOWN: begin
        moving     = 1'b1;
        next_floor = (cur_floor_q == BOT_FLOOR) ? cur_floor_q : dn_floor;
      end
      ST_DOOR: begin
        door_open = 1'b1;
      end
      default: begin
        next_floor = cur_floor_q;
      end
    endcase
  end

  assign cur_floor = cur_floor_q;
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;
  assign busy      = (state_q != ST_IDLE) || (pending_q != {NUM_FLOORS{1'b0}});

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_call_scheduler
//
// Drives inputs on the falling clock edge. After each drive it steps a
// behavioural model of the car and queues the outputs the model expects after
// the next rising edge. A separate monitor pops one expectation per rising edge
// and compares it with the DUT. Directed scenarios come first, then random
// traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_elevator_call_scheduler;

  localparam int N  = 4;
  localparam int FW = 2;
  localparam int DT = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [N-1:0]  call_req;
  logic [FW-1:0] cur_floor;
  logic [FW-1:0] next_floor;
  logic [N-1:0]  pending;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic          busy;

  elevator_call_scheduler #(
    .NUM_FLOORS(N),
    .FLOOR_W   (FW),
    .DOOR_TICKS(DT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .call_req  (call_req),
    .cur_floor (cur_floor),
    .next_floor(next_floor),
    .pending   (pending),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] cur;
    logic [FW-1:0] nxt;
    logic [N-1:0]  pend;
    logic          dir;
    logic          mov;
    logic          door;
    logic          bsy;
  } obs_t;

  obs_t exp_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   cycle_no = 0;

  // Behavioural model of the car: plain integers and a call array.
  int           m_state;
  int           m_floor;
  int           m_cnt;
  logic         m_dir;
  logic [N-1:0] m_pend;

  function automatic void model_reset();
    m_state = M_IDLE;
    m_floor = 0;
    m_cnt   = 0;
    m_dir   = 1'b1;
    m_pend  = '0;
  endfunction

  function automatic void model_step(input logic t, input logic [N-1:0] c, input logic r);
    bit           above;
    bit           below;
    bit           restart;
    logic [N-1:0] served;
    int           ns;
    int           nf;
    int           nc;
    logic         nd;
    if (r) begin
      model_reset();
      return;
    end
    above   = 0;
    below   = 0;
    served  = '0;
    ns      = m_state;
    nf      = m_floor;
    nc      = m_cnt;
    nd      = m_dir;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && i > m_floor) above = 1;
      if (m_pend[i] && i < m_floor) below = 1;
    end
    restart = (m_state == M_DOOR) && c[m_floor];
    if (t) begin
      case (m_state)
        M_IDLE: begin
          if (m_pend[m_floor]) begin
            ns = M_DOOR; served[m_floor] = 1'b1; nc = DT - 1;
          end else if (above && below) begin
            ns = m_dir ? M_UP : M_DOWN;
          end else if (above) begin
            ns = M_UP; nd = 1'b1;
          end else if (below) begin
            ns = M_DOWN; nd = 1'b0;
          end
        end
        M_UP: begin
          if (!above) ns = M_IDLE;
          else begin
            nf = m_floor + 1;
            if (m_pend[nf]) begin ns = M_DOOR; served[nf] = 1'b1; nc = DT - 1; end
          end
        end
        M_DOWN: begin
          if (!below) ns = M_IDLE;
          else begin
            nf = m_floor - 1;
            if (m_pend[nf]) begin ns = M_DOOR; served[nf] = 1'b1; nc = DT - 1; end
          end
        end
        default: begin
          if (m_cnt > 0) nc = m_cnt - 1;
          else ns = M_IDLE;
        end
      endcase
    end
    if (restart) begin
      ns = M_DOOR;
      nc = DT - 1;
    end
    for (int i = 0; i < N; i++) begin
      if (c[i] && !(m_state == M_DOOR && i == m_floor)) m_pend[i] = 1'b1;
    end
    m_pend  = m_pend & ~served;
    m_state = ns;
    m_floor = nf;
    m_cnt   = nc;
    m_dir   = nd;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.cur = FW'(m_floor);
    o.nxt = FW'(m_floor);
    if (m_state == M_UP && m_floor < N - 1) o.nxt = FW'(m_floor + 1);
    if (m_state == M_DOWN && m_floor > 0)   o.nxt = FW'(m_floor - 1);
    o.pend = m_pend;
    o.dir  = m_dir;
    o.mov  = (m_state == M_UP) || (m_state == M_DOWN);
    o.door = (m_state == M_DOOR);
    o.bsy  = (m_state != M_IDLE) || (m_pend != '0);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.cur  = cur_floor;
    o.nxt  = next_floor;
    o.pend = pending;
    o.dir  = dir_up;
    o.mov  = moving;
    o.door = door_open;
    o.bsy  = busy;
    return o;
  endfunction

  task automatic check(input string name, input obs_t e);
    obs_t g;
    g = dut_obs();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s cycle %0d: got cur=%0d nxt=%0d pend=%b dir=%b mov=%b door=%b busy=%b ; want cur=%0d nxt=%0d pend=%b dir=%b mov=%b door=%b busy=%b",
               name, cycle_no, g.cur, g.nxt, g.pend, g.dir, g.mov, g.door, g.bsy,
               e.cur, e.nxt, e.pend, e.dir, e.mov, e.door, e.bsy);
    end
  endtask

  // One clock of stimulus: drive, step the model, queue the expectation.
  task automatic cyc(input logic t, input logic [N-1:0] c, input logic r);
    @(negedge clk);
    tick     = t;
    call_req = c;
    reset    = r;
    model_step(t, c, r);
    exp_q.push_back(model_obs());
    cycle_no++;
  endtask

  // n ticks, each preceded by a non-tick clock so hold behaviour is exercised.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, '0, 1'b0);
      cyc(1'b1, '0, 1'b0);
    end
  endtask

  // Assert reset between clock edges and check that it takes effect at once.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    tick     = 1'b0;
    call_req = '0;
    reset    = 1'b1;
    model_step(1'b0, '0, 1'b1);
    #1;
    check("async_reset", model_obs());
    exp_q.push_back(model_obs());
    cycle_no++;
  endtask

  // Monitor: after every rising edge, compare against the queued expectation.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("step", e);
      end
    end
  end

  initial begin
    logic         t;
    logic         r;
    logic [N-1:0] c;
    int           sel;
    reset    = 1'b1;
    tick     = 1'b0;
    call_req = '0;
    model_reset();
    #1;
    check("reset_state", model_obs());

    // Calls and ticks while reset is held must be ignored.
    cyc(1'b1, 4'b1111, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Single call to floor 2: travel up, open door, return to idle.
    cyc(1'b0, 4'b0100, 1'b0);
    ticks(6);
    // Return to floor 0, then a call at the current floor opens the door.
    cyc(1'b0, 4'b0001, 1'b0);
    ticks(8);
    cyc(1'b0, 4'b0001, 1'b0);
    ticks(4);
    // From floor 1 with calls at both ends: up first, then down.
    cyc(1'b0, 4'b0010, 1'b0);
    ticks(6);
    cyc(1'b0, 4'b1001, 1'b0);
    ticks(14);
    // Door at floor 2 at end of dwell, restart press before the closing tick.
    cyc(1'b0, 4'b0100, 1'b0);
    ticks(5);
    cyc(1'b0, 4'b0100, 1'b0);
    ticks(4);
    // Top floor: no step beyond it over many ticks.
    cyc(1'b0, 4'b1000, 1'b0);
    ticks(20);
    // Reset while moving up at floor 1 with calls at 2 and 3.
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, 4'b1100, 1'b0);
    cyc(1'b1, '0, 1'b0);
    cyc(1'b1, '0, 1'b0);
    mid_reset();
    cyc(1'b0, '0, 1'b0);
    ticks(3);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      t   = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 2)      c = N'($urandom_range(0, (1 << N) - 1));
      else if (sel < 4) c = N'(1 << $urandom_range(0, N - 1));
      else              c = '0;
      r = ($urandom_range(0, 299) == 0);
      cyc(t, c, r);
    end

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
